// File: rtl/chol_div_sched_if.sv
// rtl/chol_div_sched_if.sv - dividend feed, divider and result signals of the column scheduler
interface chol_div_sched_if #(
  parameter int IDX_W = 2
);
  logic             start;
  logic [IDX_W-1:0] col;
  logic [31:0]      diag;
  logic             num_valid;
  logic             num_ready;
  logic [31:0]      num_data;
  logic [IDX_W-1:0] num_row;
  logic             div_divisor_valid;
  logic [31:0]      div_divisor;
  logic             div_dividend_valid;
  logic [31:0]      div_dividend;
  logic [31:0]      div_out;
  logic             l_valid;
  logic [31:0]      l_data;
  logic [IDX_W-1:0] l_row;
  logic [IDX_W-1:0] l_col;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  start, col, diag, num_valid, num_data, num_row, div_out,
    output num_ready, div_divisor_valid, div_divisor, div_dividend_valid, div_dividend,
           l_valid, l_data, l_row, l_col, busy, done, err
  );

  modport master (
    output start, col, diag, num_valid, num_data, num_row, div_out,
    input  num_ready, div_divisor_valid, div_divisor, div_dividend_valid, div_dividend,
           l_valid, l_data, l_row, l_col, busy, done, err
  );
endinterface

// File: rtl/chol_div_sched.sv
// rtl/chol_div_sched.sv - Cholesky column scheduler feeding the fixed-point divider
module chol_div_sched #(
  parameter int N           = 4,
  parameter int DIV_LATENCY = 36,
  parameter int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clken,
  chol_div_sched_if.slave bus
);
  // One spare bit so counts up to N-1 never wrap in the comparisons.
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] col_q;
  logic [31:0]      diag_q;
  logic [CNT_W-1:0] expected, issued, results, exp_new;
  logic             busy_q, done_q, err_q;
  logic             dvd_valid_q;
  logic [31:0]      dvd_q;
  logic [IDX_W-1:0] issue_row_q;
  logic             tag_v   [DIV_LATENCY];
  logic [IDX_W-1:0] tag_row [DIV_LATENCY];
  logic             num_ready_c, xfer, l_valid_c, start_acc;

  // Off-diagonal rows below the diagonal: N-1-col of them.
  assign exp_new     = CNT_W'(N - 1) - CNT_W'(bus.col);
  assign num_ready_c = clken && (state == ISSUE) && (issued < expected);
  assign xfer        = num_ready_c && bus.num_valid;
  // The divider has no valid; the oldest tag marks the cycle its quotient is on div_out.
  assign l_valid_c   = clken && tag_v[DIV_LATENCY-1];
  assign start_acc   = clken && (state == IDLE) && bus.start;

  // Next-state logic; nothing moves on a clken-low cycle.
  always_comb begin
    state_nx = state;
    if (clken) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.diag == 32'h0 || exp_new == '0) state_nx = FIN;
            else                                    state_nx = ISSUE;
          end
        end
        ISSUE: if (xfer && issued == expected - CNT_W'(1)) state_nx = DRAIN;
        DRAIN: if (results + CNT_W'(l_valid_c) == expected) state_nx = FIN;
        FIN:   state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)        state <= IDLE;
    else if (clken) state <= state_nx;
  end

  // Column context, counters and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      diag_q   <= '0;
      expected <= '0;
      issued   <= '0;
      results  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (clken) begin
      if (xfer)          issued  <= issued + CNT_W'(1);
      if (l_valid_c)     results <= results + CNT_W'(1);
      if (state == FIN)  busy_q  <= 1'b0;
      if (start_acc) begin
        col_q    <= bus.col;
        diag_q   <= bus.diag;
        expected <= exp_new;
        issued   <= '0;
        results  <= '0;
        busy_q   <= 1'b1;
      end
      done_q <= (state_nx == FIN);
      err_q  <= start_acc && (bus.diag == 32'h0);
    end
  end

  // Issue register: dividend and its row are presented the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_valid_q <= 1'b0;
      dvd_q       <= '0;
      issue_row_q <= '0;
    end else if (clken) begin
      dvd_valid_q <= xfer;
      if (xfer) begin
        dvd_q       <= bus.num_data;
        issue_row_q <= bus.num_row;
      end
    end
  end

  // Tag pipeline matched to the divider latency, fed from the issue register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIV_LATENCY; i++) begin
        tag_v[i]   <= 1'b0;
        tag_row[i] <= '0;
      end
    end else if (clken) begin
      tag_v[0]   <= dvd_valid_q;
      tag_row[0] <= issue_row_q;
      for (int i = 1; i < DIV_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_row[i] <= tag_row[i-1];
      end
    end
  end

  assign bus.num_ready          = num_ready_c;
  assign bus.div_divisor_valid  = dvd_valid_q;
  assign bus.div_divisor        = diag_q;
  assign bus.div_dividend_valid = dvd_valid_q;
  assign bus.div_dividend       = dvd_q;
  assign bus.l_valid            = l_valid_c;
  assign bus.l_data             = bus.div_out;
  assign bus.l_row              = tag_row[DIV_LATENCY-1];
  assign bus.l_col              = col_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.err                = err_q;
endmodule
